// File: rtl/net_pkg.sv
// Shared network definitions for board-state and player-state decode.
// Word type codes, grid geometry and the board receiver state type.
package net_pkg;

  localparam int COLS   = 8;
  localparam int ROWS   = 13;
  localparam int CELL_W = 4;

  localparam logic [2:0] DTYPE_PSTATE       = 3'd0;
  localparam logic [2:0] DTYPE_START_BSTATE = 3'd1;
  localparam logic [2:0] DTYPE_ACK          = 3'd2;

  localparam logic [31:0] START_WORD = {29'd0, DTYPE_START_BSTATE};

  typedef logic [COLS-1:0][ROWS-1:0][CELL_W-1:0] obj_grid_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROWS,
    S_TIME,
    S_PSTATE
  } rx_state_t;

endpackage

// File: rtl/board_rx.sv
// Board-state frame receiver for secondary consoles.
// Builds the object grid in a shadow copy and commits it atomically.
import net_pkg::*;

module board_rx #(
  parameter int TIMEOUT = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_valid,
  input  logic [31:0]          rx_data,
  output logic                 busy,
  output logic [7:0][12:0][3:0] object_grid_out,
  output logic [15:0]          time_out,
  output logic [2:0]           game_state_out,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [7:0]           frame_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  rx_state_t         state;
  logic [3:0]        row;
  logic [TW-1:0]     timer;
  obj_grid_t         shadow;
  logic [15:0]       shadow_time;
  logic [CELL_W-1:0] cells [COLS];
  logic              trailer_ok;

  // Column c of a row word; column 0 sits in the top nibble.
  for (genvar c = 0; c < COLS; c++) begin : g_unpack
    assign cells[c] = rx_data[(COLS-1-c)*CELL_W +: CELL_W];
  end

  assign trailer_ok = (rx_data[31:30] == 2'b00) &&
                      (rx_data[2:0] == DTYPE_PSTATE);

  // Frame FSM: shadow assembly, inter-word timer, commit/abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      row             <= '0;
      timer           <= '0;
      shadow          <= '0;
      shadow_time     <= '0;
      busy            <= 1'b0;
      object_grid_out <= '0;
      time_out        <= '0;
      game_state_out  <= '0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
      frame_count     <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (state == S_IDLE) begin
        if (rx_valid && enable && rx_data == START_WORD) begin
          state <= S_ROWS;
          row   <= '0;
          timer <= '0;
          busy  <= 1'b1;
        end
      end else if (!enable) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        frame_error <= 1'b1;
      end else if (rx_valid) begin
        timer <= '0;
        unique case (state)
          S_ROWS: begin
            for (int c = 0; c < COLS; c++) begin
              shadow[c][row] <= cells[c];
            end
            if (row == ROW_LAST) begin
              state <= S_TIME;
            end else begin
              row <= row + 4'd1;
            end
          end
          S_TIME: begin
            shadow_time <= rx_data[15:0];
            state       <= S_PSTATE;
          end
          S_PSTATE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (trailer_ok) begin
              object_grid_out <= shadow;
              time_out        <= shadow_time;
              game_state_out  <= rx_data[5:3];
              frame_done      <= 1'b1;
              frame_count     <= frame_count + 8'd1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timer == T_LAST) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        frame_error <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
